// File: rtl/mem_wb_ctrl.sv
// M-stage data-memory controller (req/ack handshake) and MEM/WB pipeline register.
// Optional wait-cycle watchdog enabled by defining DM_TIMEOUT_EN.
module mem_wb_ctrl #(
    parameter int pc_size   = 18,
    parameter int data_size = 32,
    parameter int addr_size = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M_MemtoReg,
    input  logic                 M_RegWrite,
    input  logic                 M_MemWrite,
    input  logic                 M_Jal,
    input  logic [data_size-1:0] M_ALU_result,
    input  logic [data_size-1:0] M_Rt_data,
    input  logic [pc_size-1:0]   M_PCplus8,
    input  logic [4:0]           M_WR_out,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [addr_size-1:0] dm_addr,
    output logic [data_size-1:0] dm_wdata,
    input  logic                 dm_ack,
    input  logic [data_size-1:0] dm_rdata,
    output logic                 stall,
    output logic                 WB_RegWrite,
    output logic [4:0]           WB_WR_out,
    output logic [data_size-1:0] WB_WD,
    output logic                 dm_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t               state_reg;
    logic [data_size-1:0] rdata_reg;
    logic                 mem_op;
    logic                 stall_int;
    logic                 timeout_hit;

    assign mem_op = M_MemtoReg | M_MemWrite;

    always_comb begin
        stall_int = 1'b0;
        case (state_reg)
            IDLE:    stall_int = mem_op;
            WAIT:    stall_int = 1'b1;
            default: stall_int = 1'b0;
        endcase
    end

    // Gated by reset so a held memory instruction cannot stall the pipe while in reset.
    assign stall = rst & stall_int;

`ifdef DM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_reg;

    assign timeout_hit = (state_reg == WAIT) && (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg <= '0;
            dm_err       <= 1'b0;
        end else begin
            if (state_reg == WAIT && !dm_ack)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            else
                wait_cnt_reg <= '0;
            if (timeout_hit && !dm_ack)
                dm_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign dm_err         = 1'b0;
`endif

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            rdata_reg   <= '0;
            WB_RegWrite <= 1'b0;
            WB_WR_out   <= '0;
            WB_WD       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_op) begin
                        dm_addr   <= M_ALU_result[addr_size+1:2];
                        dm_wdata  <= M_Rt_data;
                        dm_we     <= M_MemWrite;
                        dm_req    <= 1'b1;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (dm_ack) begin
                        rdata_reg <= dm_rdata;
                        dm_req    <= 1'b0;
                        state_reg <= DONE;
                    end else if (timeout_hit) begin
                        rdata_reg <= '0;
                        dm_req    <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A stalled edge inserts a bubble so the instruction writes back exactly once.
            if (stall_int) begin
                WB_RegWrite <= 1'b0;
            end else begin
                WB_RegWrite <= M_RegWrite;
                WB_WR_out   <= M_WR_out;
                if (M_Jal)
                    WB_WD <= {{(data_size - pc_size){1'b0}}, M_PCplus8};
                else if (M_MemtoReg)
                    WB_WD <= rdata_reg;
                else
                    WB_WD <= M_ALU_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Randomized bench for mem_wb_ctrl: instruction-level scoreboard with a word-addressed memory model.
// Inputs change and outputs are sampled around posedge; the DUT updates on negedge.
module tb_mem_wb_ctrl;

    localparam int PW = 18;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          M_MemtoReg = 1'b0;
    logic          M_RegWrite = 1'b0;
    logic          M_MemWrite = 1'b0;
    logic          M_Jal = 1'b0;
    logic [DW-1:0] M_ALU_result = '0;
    logic [DW-1:0] M_Rt_data = '0;
    logic [PW-1:0] M_PCplus8 = '0;
    logic [4:0]    M_WR_out = '0;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack = 1'b0;
    logic [DW-1:0] dm_rdata = '0;
    logic          stall;
    logic          WB_RegWrite;
    logic [4:0]    WB_WR_out;
    logic [DW-1:0] WB_WD;
    logic          dm_err;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_txn = 0;
    logic          err_exp = 1'b0;
    logic [31:0]   mem_model [int];

    mem_wb_ctrl #(
        .pc_size  (PW),
        .data_size(DW),
        .addr_size(AW),
        .TIMEOUT  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .M_MemtoReg  (M_MemtoReg),
        .M_RegWrite  (M_RegWrite),
        .M_MemWrite  (M_MemWrite),
        .M_Jal       (M_Jal),
        .M_ALU_result(M_ALU_result),
        .M_Rt_data   (M_Rt_data),
        .M_PCplus8   (M_PCplus8),
        .M_WR_out    (M_WR_out),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .stall       (stall),
        .WB_RegWrite (WB_RegWrite),
        .WB_WR_out   (WB_WR_out),
        .WB_WD       (WB_WD),
        .dm_err      (dm_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // kind: 0 = ALU, 1 = jal, 2 = load, 3 = store. n_lat = WAIT cycles until ack, 0 = never ack.
    // Called just after a posedge; returns at the posedge where the write-back is visible.
    task automatic run_instr(input int kind, input logic rw, input logic [4:0] wr,
                             input logic [31:0] alu, input logic [31:0] rt,
                             input logic [PW-1:0] pc8, input int n_lat);
        logic [31:0] exp_wd;
        logic [31:0] rd;
        int          waddr;
        int          n_wait;
        M_MemtoReg   = (kind == 2);
        M_MemWrite   = (kind == 3);
        M_Jal        = (kind == 1);
        M_RegWrite   = rw;
        M_WR_out     = wr;
        M_ALU_result = alu;
        M_Rt_data    = rt;
        M_PCplus8    = pc8;
        waddr        = int'((alu >> 2) & 32'h0000_FFFF);
        rd           = '0;
        if (kind < 2) begin
            dm_ack   = 1'($urandom);
            dm_rdata = $urandom;
            #1;
            check_val("idle_stall", stall, 0);
            check_val("idle_req", dm_req, 0);
            @(posedge clk);
            exp_wd = (kind == 1) ? {14'd0, pc8} : alu;
        end else begin
            dm_ack = 1'b0;
            if (kind == 2) begin
                if (!mem_model.exists(waddr))
                    mem_model[waddr] = $urandom;
                rd = mem_model[waddr];
            end else begin
                mem_model[waddr] = rt;
            end
            #1;
            check_val("req_stall", stall, 1);
            n_wait = (n_lat == 0) ? TO : n_lat;
            for (int k = 1; k <= n_wait; k++) begin
                @(posedge clk);
                check_val("wait_req", dm_req, 1);
                check_val("wait_addr", dm_addr, waddr);
                check_val("wait_we", dm_we, (kind == 3));
                check_val("wait_wdata", dm_wdata, rt);
                check_val("wait_stall", stall, 1);
                check_val("wait_bubble", WB_RegWrite, 0);
                dm_ack   = (n_lat != 0) && (k == n_lat);
                dm_rdata = dm_ack ? rd : $urandom;
            end
            @(posedge clk);
            if (n_lat == 0)
                err_exp = 1'b1;
            check_val("done_req", dm_req, 0);
            check_val("done_stall", stall, 0);
            check_val("done_bubble", WB_RegWrite, 0);
            check_val("done_err", dm_err, err_exp);
            dm_ack   = 1'($urandom);
            dm_rdata = $urandom;
            if (kind == 2)
                exp_wd = (n_lat == 0) ? 32'h0 : rd;
            else
                exp_wd = alu;
            @(posedge clk);
        end
        check_val("wb_we", WB_RegWrite, rw);
        check_val("wb_wr", WB_WR_out, wr);
        check_val("wb_wd", WB_WD, exp_wd);
        check_val("wb_err", dm_err, err_exp);
        dm_ack = 1'b0;
        n_txn++;
        $display("txn %0d kind=%0d rw=%0d wr=%0d wd=%h lat=%0d", n_txn, kind, rw, wr, exp_wd, n_lat);
    endtask

    task automatic run_random(input int count);
        int          kind;
        int          idx;
        logic [31:0] r;
        logic [31:0] alu;
        logic        rw;
        for (int i = 0; i < count; i++) begin
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, 15);
            r    = $urandom;
            alu  = (kind >= 2) ? ((r & 32'hFFFC_0003) | 32'(idx << 2)) : r;
            rw   = (kind == 3) ? 1'b0 : 1'($urandom);
            run_instr(kind, rw, 5'($urandom), alu, $urandom, PW'($urandom),
                      $urandom_range(1, TO));
        end
    endtask

    initial begin
        // Memory instruction held during reset must not raise stall.
        M_MemtoReg = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_stall", stall, 0);
        check_val("rst_req", dm_req, 0);
        check_val("rst_we", dm_we, 0);
        check_val("rst_addr", dm_addr, 0);
        check_val("rst_wdata", dm_wdata, 0);
        check_val("rst_wb_we", WB_RegWrite, 0);
        check_val("rst_wb_wr", WB_WR_out, 0);
        check_val("rst_wb_wd", WB_WD, 0);
        check_val("rst_err", dm_err, 0);
        M_MemtoReg = 1'b0;
        rst        = 1'b1;

        run_instr(0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, '0, 0);
        mem_model[16'h10] = 32'hDEAD_BEEF;
        run_instr(2, 1'b1, 5'd7, 32'h0000_0040, 32'h0, '0, 3);
        run_instr(3, 1'b0, 5'd0, 32'h0000_0080, 32'h0000_A5A5, '0, 2);
        run_instr(2, 1'b1, 5'd9, 32'h0000_0080, 32'h0, '0, 1);
        run_instr(1, 1'b1, 5'd31, 32'h0000_0099, 32'h0, 18'h3FFFC, 0);

        run_random(40);

        // Reset two cycles into WAIT abandons the access immediately.
        M_MemtoReg   = 1'b1;
        M_RegWrite   = 1'b1;
        M_ALU_result = 32'h0000_0100;
        #1;
        check_val("pre_rst_stall", stall, 1);
        repeat (2) @(posedge clk);
        check_val("pre_rst_req", dm_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_req", dm_req, 0);
        check_val("async_stall", stall, 0);
        check_val("async_addr", dm_addr, 0);
        @(posedge clk);
        rst        = 1'b1;
        M_MemtoReg = 1'b0;
        M_RegWrite = 1'b0;
        dm_ack     = 1'b1;
        err_exp    = 1'b0;
        @(posedge clk);
        check_val("stray_ack_req", dm_req, 0);
        check_val("stray_ack_stall", stall, 0);
        run_instr(0, 1'b1, 5'd12, 32'h0BAD_F00D, 32'h0, '0, 0);

        run_random(20);

`ifdef DM_TIMEOUT_EN
        run_instr(2, 1'b1, 5'd3, 32'h0000_0044, 32'h0, '0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_ctrl.md
# mem_wb_ctrl

Memory-stage controller and MEM/WB pipeline register for the five-stage MIPS core. It consumes the M-stage bundle held by the EX/MEM register, performs loads and stores against a variable-latency data memory over a req/ack handshake, and holds the upstream pipeline with `stall` while an access is outstanding. It then presents the selected write-back data, destination register and write enable to the register file.

## Interface
- `pc_size`, 18: width of `M_PCplus8`.
- `data_size`, 32: datapath width.
- `addr_size`, 16: data-memory word-address width.
- `TIMEOUT`, 255: maximum wait cycles for `dm_ack` (only with `DM_TIMEOUT_EN`).

- `clk`  in  1  pipeline clock; all state updates on negedge, matching the pipeline registers.
- `rst`  in  1  asynchronous, active-low reset.
- `M_MemtoReg`  in  1  load instruction in M.
- `M_RegWrite`  in  1  instruction writes the register file.
- `M_MemWrite`  in  1  store instruction in M.
- `M_Jal`  in  1  jal; write-back selects PC+8.
- `M_ALU_result`  in  data_size  byte address, or the ALU write-back value.
- `M_Rt_data`  in  data_size  store data.
- `M_PCplus8`  in  pc_size  return address.
- `M_WR_out`  in  5  destination register.
- `dm_req`  out  1  memory request, registered.
- `dm_we`  out  1  1 = write.
- `dm_addr`  out  addr_size  `M_ALU_result[addr_size+1:2]`, latched.
- `dm_wdata`  out  data_size  latched `M_Rt_data`.
- `dm_ack`  in  1  memory completion.
- `dm_rdata`  in  data_size  read data, valid with `dm_ack`.
- `stall`  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- `WB_RegWrite`  out  1  register-file write enable.
- `WB_WR_out`  out  5  write register.
- `WB_WD`  out  data_size  write data.
- `dm_err`  out  1  sticky timeout flag.

## Operation
- `mem_op = M_MemtoReg | M_MemWrite`.
- FSM states are IDLE, WAIT and DONE.
- **IDLE:**
  - If `mem_op` is set, `stall` is driven 1 combinationally in the same cycle.
  - At the next edge: latch address, write data and `dm_we = M_MemWrite`; set `dm_req = 1`; go to WAIT.
  - Otherwise `stall` is 0.
- **WAIT:**
  - `stall` is 1 and `dm_req`, `dm_addr`, `dm_wdata` and `dm_we` are held stable.
  - When `dm_ack` is 1 at an edge: capture `dm_rdata`, drop `dm_req`, go to DONE.
- **DONE:**
  - `stall` is 0, so the instruction retires at this edge.
  - Go to IDLE.
- MEM/WB capture happens at every edge where `stall` is 0:
  - `WB_RegWrite <= M_RegWrite`.
  - `WB_WR_out <= M_WR_out`.
  - `WB_WD` selection, priority order:
    1. `M_Jal`: zero-extended `M_PCplus8`.
    2. `M_MemToReg`: captured read data.
    3. otherwise `M_ALU_result`.
- At any edge where `stall` is 1, `WB_RegWrite <= 0` (bubble), so the register file is never written twice.
- `dm_ack` is ignored in IDLE and DONE.
- Address bits [1:0] are discarded; only word accesses are supported.

## Timing
- Reset values: `dm_req`, `dm_we`, `stall`, `WB_RegWrite` and `dm_err` are 0; `dm_addr`, `dm_wdata`, `WB_WR_out` and `WB_WD` are 0; state is IDLE.
- Reset mid-WAIT drops `dm_req` immediately (asynchronously); the access is abandoned.
- Non-memory instructions: 1-cycle latency, M to WB.
- Memory instructions:
  - `stall` high for N+1 cycles, where N is the number of cycles from `dm_req` rising to `dm_ack` sampled high (N ≥ 1).
  - WB result appears at the DONE edge.
- Back-to-back memory instructions: the second starts from IDLE after DONE, so `dm_req` has at least one low cycle between accesses.
- `dm_ack` already high in the first WAIT cycle gives N = 1, so `stall` is 2 cycles.

## Configuration
- `DM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider wait counter runs in WAIT.
  - If `TIMEOUT` cycles elapse without `dm_ack`: drop `dm_req`, force captured read data to 0, set `dm_err` (cleared only by reset), go to DONE.
- `DM_TIMEOUT_EN` undefined:
  - No counter; WAIT persists until `dm_ack`.
  - `dm_err` is tied to 0.

## Test plan
- **ALU write-back:** after reset, apply `M_RegWrite=1`, `M_WR_out=5`, `M_ALU_result=0x1234`. Next edge gives `WB_RegWrite=1`, `WB_WR_out=5`, `WB_WD=0x1234`; `stall` stays 0 and `dm_req` stays 0.
- **Load:** apply `M_MemtoReg=1`, `M_ALU_result=0x40`; ack after 3 cycles with `dm_rdata=0xDEADBEEF`.
  - `dm_addr=0x10`, `dm_we=0`.
  - `stall` high for 4 cycles.
  - `WB_RegWrite` is 0 during the stall, then 1 with `WB_WD=0xDEADBEEF`.
- **Store then load back-to-back:** `M_MemWrite=1` with `Rt=0xA5A5`.
  - `dm_we=1`, `dm_wdata=0xA5A5`.
  - `dm_req` goes low for at least one cycle before the load's request.
  - Store gives `WB_RegWrite=0`.
- **Jal:** `M_Jal=1`, `M_PCplus8=0x3FFFC`, `M_ALU_result=0x99` gives `WB_WD=0x0003FFFC`.
- **Reset during WAIT:** pull `rst` low 2 cycles into WAIT. `dm_req` and `stall` go to 0 immediately; after release the FSM is in IDLE and a stray `dm_ack` has no effect.
- **With `DM_TIMEOUT_EN`, `TIMEOUT=4`, no ack:** after 4 WAIT cycles `dm_req` goes 0, `dm_err=1`, and the load writes `WB_WD=0`.
